fpu_sl_cluster: RTL and testbench
=================================

FPU_SL_CLUSTER -- requirements
Module: fpu_sl_cluster

Interface
REQ-001 SHALL have parameter LANES, default 3: number of independent store/shuffle lanes (1..8).
REQ-002 SHALL have parameter W, default 68: lane data width, even.
REQ-003 SHALL have parameter DEPTH, default 2: forwarding-history depth per lane (1..4).
REQ-004 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- u_A  in  LANES*W  per-lane operand A; lane l at [l*W +: W].
- u_B  in  LANES*W  per-lane operand B.
- u_en  in  LANES  per-lane issue valid.
- u_op  in  LANES*13  per-lane opcode; op[3:0] selects the function.
- u_fwdA  in  LANES*5  per-lane A source code.
- u_fwdB  in  LANES*5  per-lane B source code.
- u_ret  out  LANES*14  per-lane retire status.
- u_ret_en  out  LANES  per-lane retire valid.
- fuf  out  LANES*DEPTH*W  forwarding history; slot (l,d) at [(l*DEPTH+d)*W +: W].
- alt_inp  in  1  alternate-data request pulse.
- alt_data  in  W  alternate data.
- xi_data  out  W  alternate data output.
- xi_valid  out  1  xi_data valid, one cycle.
- alt_ovf  out  1  sticky alternate-overflow flag.

Function
REQ-005 Stage S1 SHALL register, per lane, en, op and resolved A and B; S2 SHALL register result and status; issue at edge t SHALL give u_ret_en and fuf slot (l,0) at edge t+2.
REQ-006 Source code 0 SHALL select the u_A/u_B port; code k in 1..LANES*DEPTH SHALL select flat fuf slot k-1 as seen before the capturing edge; any larger code SHALL select the port and set ret[2] for that op.
REQ-007 op[3:0] SHALL compute: 0 A; 1 B; 2 A&B; 3 A|B; 4 A^B; 5 A&~B; 6 {A[W/2-1:0],A[W-1:W/2]}; 7 all-ones if A==B, else zero.
REQ-008 op[3:0] 8..15 SHALL produce result 0 and set ret[1].
REQ-009 u_ret SHALL be {op[12:4], 2'b0, ret[2], ret[1], 1'b1} on valid cycles and 0 otherwise.
REQ-010 Each edge, every lane SHALL shift its history: slot (l,d) <= (l,d-1) for d>=1, and slot (l,0) <= the S2 result when valid, else 0.
REQ-011 Lanes SHALL operate independently; simultaneous issue on all lanes SHALL be supported every cycle with no stall.
REQ-012 An alt_inp pulse SHALL drive xi_valid=1 and xi_data=alt_data one cycle later, if lane LANES-1 has no valid S1 op that cycle.
REQ-013 If lane LANES-1 S1 is valid, the alt request SHALL go to a 1-entry pending buffer and issue on the first cycle that S1 is not valid.
REQ-014 A new alt_inp while the pending buffer is full SHALL overwrite the buffered data and set alt_ovf.
REQ-015 alt_ovf SHALL stay set until reset.
REQ-016 Pending data SHALL issue before newly arriving alt data.
REQ-017 xi_data SHALL hold its last value while xi_valid=0.

Reset
REQ-018 While rst=0, all pipeline valids, u_ret, u_ret_en, fuf, xi_data, xi_valid, alt_ovf and the pending buffer SHALL be 0, asynchronously.
REQ-019 In-flight ops at reset assertion SHALL be discarded and SHALL never retire.
REQ-020 First issue SHALL be accepted at the first clk edge with rst=1.

Verification
REQ-021 Lane 0: u_en=1, op=4, A=0x0F..0F, B=0xFF..FF -> edge t+2: u_ret_en[0]=1, fuf(0,0)=0xF0..F0, ret=0x001.
REQ-022 Lane 1 issues op=0 with fwdA=1 two edges after lane 0 writes R into fuf(0,0) -> lane 1 result R; one edge later fuf(0,1)=R.
REQ-023 op=9 on lane 2 -> result 0, ret[1]=1; fwdA=31 -> port A used, ret[2]=1.
REQ-024 alt_inp with lane 2 S1 busy for 3 cycles, then second alt_inp -> alt_ovf=1; single xi_valid with second data after S1 frees.
REQ-025 rst=0 mid-flight, 1 cycle after issue -> no u_ret_en; all fuf slots 0.
REQ-026 LANES=1, DEPTH=4 build: history shift visible over 4 consecutive issues; codes 5..31 flagged.

Source files
------------

// File: rtl/fpu_sl_cluster_if.sv
// rtl/fpu_sl_cluster_if.sv - issue/retire/history/alternate-data bundle for fpu_sl_cluster
//
// Ports carried (LANES lanes of W bits, DEPTH history slots per lane):
//   u_A, u_B       per-lane operands, lane l at [l*W +: W]
//   u_en           per-lane issue valid
//   u_op           per-lane opcode, 13 bits per lane
//   u_fwdA, u_fwdB per-lane operand source codes, 5 bits per lane
//   u_ret          per-lane retire status, 14 bits per lane
//   u_ret_en       per-lane retire valid
//   fuf            forwarding history, slot (l,d) at [(l*DEPTH+d)*W +: W]
//   alt_inp        alternate-data request pulse
//   alt_data       alternate data in
//   xi_data        alternate data out
//   xi_valid       xi_data valid for one cycle
//   alt_ovf        sticky alternate-overflow flag
interface fpu_sl_cluster_if #(
    parameter int LANES = 3,
    parameter int W     = 68,
    parameter int DEPTH = 2
);
    logic [LANES*W-1:0]       u_A;
    logic [LANES*W-1:0]       u_B;
    logic [LANES-1:0]         u_en;
    logic [LANES*13-1:0]      u_op;
    logic [LANES*5-1:0]       u_fwdA;
    logic [LANES*5-1:0]       u_fwdB;
    logic [LANES*14-1:0]      u_ret;
    logic [LANES-1:0]         u_ret_en;
    logic [LANES*DEPTH*W-1:0] fuf;
    logic                     alt_inp;
    logic [W-1:0]             alt_data;
    logic [W-1:0]             xi_data;
    logic                     xi_valid;
    logic                     alt_ovf;

    modport master (
        output u_A, u_B, u_en, u_op, u_fwdA, u_fwdB, alt_inp, alt_data,
        input  u_ret, u_ret_en, fuf, xi_data, xi_valid, alt_ovf
    );

    modport slave (
        input  u_A, u_B, u_en, u_op, u_fwdA, u_fwdB, alt_inp, alt_data,
        output u_ret, u_ret_en, fuf, xi_data, xi_valid, alt_ovf
    );
endinterface

// File: rtl/fpu_sl_cluster.sv
// rtl/fpu_sl_cluster.sv - multi-lane store/shuffle cluster with forwarding history and alternate-data path
//
// Ports:
//   clk  single clock, all state on rising edge
//   rst  asynchronous active-low reset
//   bus  fpu_sl_cluster_if.slave: lane issue inputs, retire status, history
//        vector and the alternate-data request/response signals
//
// Pipeline per lane: S1 (operands resolved and registered) -> S2 (result and
// status registered) -> retire registers and history slot 0. An op issued at
// edge t retires, and lands in history slot (l,0), at edge t+2.
module fpu_sl_cluster #(
    parameter int LANES = 3,
    parameter int W     = 68,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    fpu_sl_cluster_if.slave bus
);
    localparam int NSLOT = LANES * DEPTH;
    localparam int HW    = W / 2;

    // S1
    logic [LANES-1:0]         s1_en_q,   s1_en_d;
    logic [LANES-1:0][12:0]   s1_op_q,   s1_op_d;
    logic [LANES-1:0][W-1:0]  s1_a_q,    s1_a_d;
    logic [LANES-1:0][W-1:0]  s1_b_q,    s1_b_d;
    logic [LANES-1:0]         s1_ferr_q, s1_ferr_d;
    // S2
    logic [LANES-1:0]         s2_en_q,   s2_en_d;
    logic [LANES-1:0][W-1:0]  s2_res_q,  s2_res_d;
    logic [LANES-1:0][13:0]   s2_ret_q,  s2_ret_d;
    // retire and history
    logic [LANES-1:0]         ret_en_q;
    logic [LANES-1:0][13:0]   ret_q;
    logic [NSLOT-1:0][W-1:0]  fuf_q,     fuf_d;
    // alternate-data path
    logic                     pend_q,      pend_d;
    logic [W-1:0]             pend_data_q, pend_data_d;
    logic                     xi_valid_q,  xi_valid_d;
    logic [W-1:0]             xi_data_q,   xi_data_d;
    logic                     ovf_q,       ovf_d;
    logic                     lane_busy;

    // Operand resolution: code 0 is the port, 1..NSLOT picks a flat history
    // slot as it stands before this edge, anything larger falls back to the
    // port and is reported in the retire status.
    always_comb begin
        s1_en_d   = bus.u_en;
        s1_op_d   = '0;
        s1_a_d    = '0;
        s1_b_d    = '0;
        s1_ferr_d = '0;
        for (int l = 0; l < LANES; l++) begin
            s1_op_d[l]   = bus.u_op[l*13 +: 13];
            s1_a_d[l]    = bus.u_A[l*W +: W];
            s1_b_d[l]    = bus.u_B[l*W +: W];
            s1_ferr_d[l] = (int'(bus.u_fwdA[l*5 +: 5]) > NSLOT) ||
                           (int'(bus.u_fwdB[l*5 +: 5]) > NSLOT);
            for (int k = 0; k < NSLOT; k++) begin
                if (int'(bus.u_fwdA[l*5 +: 5]) == k + 1) s1_a_d[l] = fuf_q[k];
                if (int'(bus.u_fwdB[l*5 +: 5]) == k + 1) s1_b_d[l] = fuf_q[k];
            end
        end
    end

    // Function units. Invalid slots carry zero result and zero status so the
    // history shift can take S2 unconditionally.
    always_comb begin
        s2_en_d  = s1_en_q;
        s2_res_d = '0;
        s2_ret_d = '0;
        for (int l = 0; l < LANES; l++) begin
            if (s1_en_q[l]) begin
                case (s1_op_q[l][3:0])
                    4'd0:    s2_res_d[l] = s1_a_q[l];
                    4'd1:    s2_res_d[l] = s1_b_q[l];
                    4'd2:    s2_res_d[l] = s1_a_q[l] & s1_b_q[l];
                    4'd3:    s2_res_d[l] = s1_a_q[l] | s1_b_q[l];
                    4'd4:    s2_res_d[l] = s1_a_q[l] ^ s1_b_q[l];
                    4'd5:    s2_res_d[l] = s1_a_q[l] & ~s1_b_q[l];
                    4'd6:    s2_res_d[l] = {s1_a_q[l][HW-1:0], s1_a_q[l][W-1:HW]};
                    4'd7:    s2_res_d[l] = (s1_a_q[l] == s1_b_q[l]) ? {W{1'b1}} : {W{1'b0}};
                    default: s2_res_d[l] = '0;
                endcase
                // opcodes 8..15 are exactly those with bit 3 set
                s2_ret_d[l] = {s1_op_q[l][12:4], 2'b00, s1_ferr_q[l], s1_op_q[l][3], 1'b1};
            end
        end
    end

    always_comb begin
        fuf_d = fuf_q;
        for (int l = 0; l < LANES; l++) begin
            fuf_d[l*DEPTH] = s2_res_q[l];
            for (int d = 1; d < DEPTH; d++) begin
                fuf_d[l*DEPTH + d] = fuf_q[l*DEPTH + d - 1];
            end
        end
    end

    // The alternate path shares the output slot with the last lane's S1; a
    // parked request always goes out ahead of a newly arriving one.
    assign lane_busy = s1_en_q[LANES-1];

    always_comb begin
        xi_valid_d  = 1'b0;
        xi_data_d   = xi_data_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        ovf_d       = ovf_q;
        if (!lane_busy) begin
            if (pend_q) begin
                xi_valid_d = 1'b1;
                xi_data_d  = pend_data_q;
                pend_d     = bus.alt_inp;
                if (bus.alt_inp) pend_data_d = bus.alt_data;
            end else if (bus.alt_inp) begin
                xi_valid_d = 1'b1;
                xi_data_d  = bus.alt_data;
            end
        end else if (bus.alt_inp) begin
            if (pend_q) ovf_d = 1'b1;
            pend_d      = 1'b1;
            pend_data_d = bus.alt_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_en_q     <= '0;
            s1_op_q     <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_ferr_q   <= '0;
            s2_en_q     <= '0;
            s2_res_q    <= '0;
            s2_ret_q    <= '0;
            ret_en_q    <= '0;
            ret_q       <= '0;
            fuf_q       <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            xi_valid_q  <= 1'b0;
            xi_data_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            s1_en_q     <= s1_en_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_ferr_q   <= s1_ferr_d;
            s2_en_q     <= s2_en_d;
            s2_res_q    <= s2_res_d;
            s2_ret_q    <= s2_ret_d;
            ret_en_q    <= s2_en_q;
            ret_q       <= s2_ret_q;
            fuf_q       <= fuf_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            xi_valid_q  <= xi_valid_d;
            xi_data_q   <= xi_data_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.u_ret    = ret_q;
    assign bus.u_ret_en = ret_en_q;
    assign bus.fuf      = fuf_q;
    assign bus.xi_data  = xi_data_q;
    assign bus.xi_valid = xi_valid_q;
    assign bus.alt_ovf  = ovf_q;
endmodule

// File: tb/tb_fpu_sl_cluster.sv
// tb/tb_fpu_sl_cluster.sv - self-checking bench for fpu_sl_cluster (default build and LANES=1/DEPTH=4 build)
module tb_fpu_sl_cluster;
    localparam int L  = 3;
    localparam int W  = 68;
    localparam int D  = 2;
    localparam int NS = L * D;
    localparam int W2 = 16;
    localparam int D2 = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpu_sl_cluster_if #(.LANES(L), .W(W),  .DEPTH(D))  ifc ();
    fpu_sl_cluster_if #(.LANES(1), .W(W2), .DEPTH(D2)) ifc2 ();

    fpu_sl_cluster #(.LANES(L), .W(W),  .DEPTH(D))  dut  (.clk(clk), .rst(rst), .bus(ifc));
    fpu_sl_cluster #(.LANES(1), .W(W2), .DEPTH(D2)) dut2 (.clk(clk), .rst(rst), .bus(ifc2));

    int total = 0;
    int bad   = 0;

    // ---------------- reference model (default build) ----------------
    typedef struct {
        int          due;
        int          lane;
        logic [W-1:0] res;
        logic [13:0]  ret;
    } fly_t;

    logic [W-1:0]    m_hist [L][D];   // index 0 = newest
    fly_t            m_fly [$];
    logic [L-1:0]    m_ret_en;
    logic [L*14-1:0] m_ret;
    bit              m_pend, m_ovf, m_xiv, m_busy;
    logic [W-1:0]    m_pend_d, m_xid;
    int              m_edge;

    function automatic logic [W-1:0] rnd_w();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] ref_op(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] ones;
        ones = '1;
        case (f)
            4'd0: return a;
            4'd1: return b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a & ~b;
            4'd6: return (a >> (W/2)) | (a << (W/2));
            4'd7: return (a == b) ? ones : '0;
            default: return '0;
        endcase
    endfunction

    task automatic model_reset();
        for (int l = 0; l < L; l++) for (int d = 0; d < D; d++) m_hist[l][d] = '0;
        m_fly.delete();
        m_ret_en = '0; m_ret = '0;
        m_pend = 0; m_ovf = 0; m_xiv = 0; m_busy = 0;
        m_pend_d = '0; m_xid = '0; m_edge = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        fly_t         n;
        fly_t         newq [$];
        int           ca, cb, ln;
        bit           ferr;
        logic [12:0]  op;
        logic [W-1:0] a, b;
        for (int l = 0; l < L; l++) begin
            if (ifc.u_en[l]) begin
                ca = int'(ifc.u_fwdA[l*5 +: 5]);
                cb = int'(ifc.u_fwdB[l*5 +: 5]);
                a  = ifc.u_A[l*W +: W];
                b  = ifc.u_B[l*W +: W];
                if (ca >= 1 && ca <= NS) a = m_hist[(ca-1)/D][(ca-1)%D];
                if (cb >= 1 && cb <= NS) b = m_hist[(cb-1)/D][(cb-1)%D];
                ferr   = (ca > NS) || (cb > NS);
                op     = ifc.u_op[l*13 +: 13];
                n.due  = m_edge + 2;
                n.lane = l;
                n.res  = ref_op(op[3:0], a, b);
                n.ret  = {op[12:4], 2'b00, ferr, (op[3:0] > 4'd7), 1'b1};
                newq.push_back(n);
            end
        end
        m_xiv = 0;
        if (!m_busy) begin
            if (m_pend) begin
                m_xiv = 1; m_xid = m_pend_d;
                m_pend = ifc.alt_inp;
                if (ifc.alt_inp) m_pend_d = ifc.alt_data;
            end else if (ifc.alt_inp) begin
                m_xiv = 1; m_xid = ifc.alt_data;
            end
        end else if (ifc.alt_inp) begin
            if (m_pend) m_ovf = 1;
            m_pend = 1; m_pend_d = ifc.alt_data;
        end
        m_busy = ifc.u_en[L-1];
        m_ret_en = '0; m_ret = '0;
        for (int l = 0; l < L; l++) begin
            for (int d = D-1; d >= 1; d--) m_hist[l][d] = m_hist[l][d-1];
            m_hist[l][0] = '0;
        end
        for (int i = m_fly.size() - 1; i >= 0; i--) begin
            if (m_fly[i].due == m_edge) begin
                ln = m_fly[i].lane;
                m_hist[ln][0] = m_fly[i].res;
                m_ret_en[ln] = 1'b1;
                m_ret[ln*14 +: 14] = m_fly[i].ret;
                m_fly.delete(i);
            end
        end
        foreach (newq[i]) m_fly.push_back(newq[i]);
        m_edge++;
    endtask

    function automatic logic [NS*W-1:0] model_fuf();
        logic [NS*W-1:0] v;
        for (int l = 0; l < L; l++) for (int d = 0; d < D; d++) v[(l*D+d)*W +: W] = m_hist[l][d];
        return v;
    endfunction

    // ---------------- stimulus utilities ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifc.u_A = '0; ifc.u_B = '0; ifc.u_en = '0; ifc.u_op = '0;
        ifc.u_fwdA = '0; ifc.u_fwdB = '0; ifc.alt_inp = 1'b0; ifc.alt_data = '0;
        ifc2.u_A = '0; ifc2.u_B = '0; ifc2.u_en = '0; ifc2.u_op = '0;
        ifc2.u_fwdA = '0; ifc2.u_fwdB = '0; ifc2.alt_inp = 1'b0; ifc2.alt_data = '0;
    endtask

    function automatic logic [W-1:0] slot(input int l, input int d);
        return ifc.fuf[(l*D+d)*W +: W];
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        rst = 1'b1;
        #2 rst = 1'b0;
        cyc(); cyc();
        total++; if (ifc.u_ret_en !== '0) begin bad++; $display("FAIL rst_ret_en got=%b exp=0", ifc.u_ret_en); end
        total++; if (ifc.u_ret !== '0) begin bad++; $display("FAIL rst_ret got=%h exp=0", ifc.u_ret); end
        total++; if (ifc.fuf !== '0) begin bad++; $display("FAIL rst_fuf got=%h exp=0", ifc.fuf); end
        total++; if (ifc.xi_valid !== 1'b0 || ifc.xi_data !== '0) begin bad++; $display("FAIL rst_xi got=%b/%h exp=0/0", ifc.xi_valid, ifc.xi_data); end
        total++; if (ifc.alt_ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", ifc.alt_ovf); end
        total++; if (ifc2.fuf !== '0) begin bad++; $display("FAIL rst_fuf2 got=%h exp=0", ifc2.fuf); end
        rst = 1'b1;
    endtask

    task automatic test_xor();
        logic [W-1:0] a;
        for (int i = 0; i < W/4; i++) a[i*4 +: 4] = (i % 2 == 0) ? 4'hF : 4'h0;
        idle();
        ifc.u_en[0] = 1'b1; ifc.u_op[12:0] = 13'd4;
        ifc.u_A[W-1:0] = a; ifc.u_B[W-1:0] = '1;
        cyc();
        idle();
        cyc();
        total++; if (ifc.u_ret_en !== 3'b000) begin bad++; $display("FAIL xor_early got=%b exp=000", ifc.u_ret_en); end
        cyc();
        total++; if (ifc.u_ret_en !== 3'b001) begin bad++; $display("FAIL xor_ret_en got=%b exp=001", ifc.u_ret_en); end
        total++; if (ifc.u_ret[13:0] !== 14'h001) begin bad++; $display("FAIL xor_ret got=%h exp=001", ifc.u_ret[13:0]); end
        total++; if (slot(0,0) !== ~a) begin bad++; $display("FAIL xor_res got=%h exp=%h", slot(0,0), ~a); end
        cyc();
        total++; if (ifc.u_ret_en !== 3'b000 || ifc.u_ret !== '0) begin bad++; $display("FAIL xor_drop got=%b/%h exp=0/0", ifc.u_ret_en, ifc.u_ret); end
        total++; if (slot(0,1) !== ~a || slot(0,0) !== '0) begin bad++; $display("FAIL xor_shift got=%h/%h exp=%h/0", slot(0,1), slot(0,0), ~a); end
    endtask

    task automatic test_forward();
        logic [W-1:0] r;
        r = rnd_w();
        idle();
        ifc.u_en[0] = 1'b1; ifc.u_op[12:0] = 13'd1; ifc.u_B[W-1:0] = r;
        cyc();
        idle();
        cyc(); cyc();
        total++; if (slot(0,0) !== r) begin bad++; $display("FAIL fwd_src got=%h exp=%h", slot(0,0), r); end
        ifc.u_en[1] = 1'b1; ifc.u_op[25:13] = 13'd0; ifc.u_fwdA[9:5] = 5'd1; ifc.u_A[2*W-1:W] = ~r;
        cyc();
        idle();
        total++; if (slot(0,1) !== r) begin bad++; $display("FAIL fwd_hist got=%h exp=%h", slot(0,1), r); end
        cyc(); cyc();
        total++; if (ifc.u_ret_en !== 3'b010) begin bad++; $display("FAIL fwd_ret_en got=%b exp=010", ifc.u_ret_en); end
        total++; if (slot(1,0) !== r) begin bad++; $display("FAIL fwd_res got=%h exp=%h", slot(1,0), r); end
        total++; if (ifc.u_ret[27:14] !== 14'h001) begin bad++; $display("FAIL fwd_ret got=%h exp=001", ifc.u_ret[27:14]); end
    endtask

    task automatic test_bad_op();
        logic [W-1:0] a;
        logic [W-1:0] ones;
        ones = '1;
        a = rnd_w();
        idle();
        ifc.u_en[2] = 1'b1; ifc.u_op[38:26] = {9'h123, 4'd9}; ifc.u_A[3*W-1:2*W] = a;
        cyc();
        ifc.u_op[38:26] = {9'h0A5, 4'd7}; ifc.u_fwdA[14:10] = 5'd31;
        ifc.u_A[3*W-1:2*W] = a; ifc.u_B[3*W-1:2*W] = a;
        cyc();
        idle();
        cyc();
        total++; if (ifc.u_ret_en !== 3'b100) begin bad++; $display("FAIL bad_ret_en got=%b exp=100", ifc.u_ret_en); end
        total++; if (ifc.u_ret[41:28] !== {9'h123, 2'b00, 1'b0, 1'b1, 1'b1}) begin bad++; $display("FAIL bad_ret got=%h exp=%h", ifc.u_ret[41:28], {9'h123, 5'b00011}); end
        total++; if (slot(2,0) !== '0) begin bad++; $display("FAIL bad_res got=%h exp=0", slot(2,0)); end
        cyc();
        total++; if (ifc.u_ret[41:28] !== {9'h0A5, 2'b00, 1'b1, 1'b0, 1'b1}) begin bad++; $display("FAIL code31_ret got=%h exp=%h", ifc.u_ret[41:28], {9'h0A5, 5'b00101}); end
        total++; if (slot(2,0) !== ones) begin bad++; $display("FAIL code31_res got=%h exp=%h", slot(2,0), ones); end
        cyc();
    endtask

    task automatic test_alt();
        logic [W-1:0] d0, d1, d2;
        d0 = rnd_w(); d1 = rnd_w(); d2 = ~d1;
        idle();
        ifc.alt_inp = 1'b1; ifc.alt_data = d0;
        cyc();
        total++; if (ifc.xi_valid !== 1'b1 || ifc.xi_data !== d0) begin bad++; $display("FAIL alt_direct got=%b/%h exp=1/%h", ifc.xi_valid, ifc.xi_data, d0); end
        idle();
        cyc();
        total++; if (ifc.xi_valid !== 1'b0 || ifc.xi_data !== d0) begin bad++; $display("FAIL alt_hold got=%b/%h exp=0/%h", ifc.xi_valid, ifc.xi_data, d0); end
        ifc.u_en[2] = 1'b1;
        cyc();
        ifc.alt_inp = 1'b1; ifc.alt_data = d1;
        cyc();
        total++; if (ifc.xi_valid !== 1'b0 || ifc.alt_ovf !== 1'b0) begin bad++; $display("FAIL alt_park got=%b/%b exp=0/0", ifc.xi_valid, ifc.alt_ovf); end
        ifc.alt_data = d2;
        cyc();
        total++; if (ifc.xi_valid !== 1'b0 || ifc.alt_ovf !== 1'b1) begin bad++; $display("FAIL alt_ovf got=%b/%b exp=0/1", ifc.xi_valid, ifc.alt_ovf); end
        idle();
        cyc();
        total++; if (ifc.xi_valid !== 1'b0) begin bad++; $display("FAIL alt_wait got=%b exp=0", ifc.xi_valid); end
        cyc();
        total++; if (ifc.xi_valid !== 1'b1 || ifc.xi_data !== d2) begin bad++; $display("FAIL alt_drain got=%b/%h exp=1/%h", ifc.xi_valid, ifc.xi_data, d2); end
        cyc();
        total++; if (ifc.xi_valid !== 1'b0 || ifc.xi_data !== d2 || ifc.alt_ovf !== 1'b1) begin bad++; $display("FAIL alt_after got=%b/%h/%b exp=0/%h/1", ifc.xi_valid, ifc.xi_data, ifc.alt_ovf, d2); end
    endtask

    task automatic test_reset_midflight();
        logic [W-1:0]   x;
        logic [NS*W-1:0] e;
        idle();
        ifc.u_en = 3'b111;
        ifc.u_A = {rnd_w(), rnd_w(), rnd_w()};
        cyc();
        idle();
        cyc();
        rst = 1'b0;
        #1;
        total++; if (ifc.u_ret_en !== '0 || ifc.u_ret !== '0) begin bad++; $display("FAIL mid_ret got=%b/%h exp=0/0", ifc.u_ret_en, ifc.u_ret); end
        total++; if (ifc.fuf !== '0) begin bad++; $display("FAIL mid_fuf got=%h exp=0", ifc.fuf); end
        total++; if (ifc.alt_ovf !== 1'b0 || ifc.xi_data !== '0) begin bad++; $display("FAIL mid_alt got=%b/%h exp=0/0", ifc.alt_ovf, ifc.xi_data); end
        cyc();
        rst = 1'b1;
        x = rnd_w();
        ifc.u_en[0] = 1'b1; ifc.u_A[W-1:0] = x;
        cyc();
        idle();
        total++; if (ifc.u_ret_en !== '0) begin bad++; $display("FAIL mid_ghost1 got=%b exp=0", ifc.u_ret_en); end
        cyc();
        total++; if (ifc.u_ret_en !== '0) begin bad++; $display("FAIL mid_ghost2 got=%b exp=0", ifc.u_ret_en); end
        cyc();
        e = '0; e[W-1:0] = x;
        total++; if (ifc.u_ret_en !== 3'b001) begin bad++; $display("FAIL first_issue got=%b exp=001", ifc.u_ret_en); end
        total++; if (ifc.fuf !== e) begin bad++; $display("FAIL first_fuf got=%h exp=%h", ifc.fuf, e); end
    endtask

    task automatic test_random(input int n);
        logic [L*W-1:0]  a, b;
        logic [L-1:0]    en;
        logic [L*13-1:0] op;
        logic [L*5-1:0]  fa, fb;
        int              r;
        idle();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        model_reset();
        for (int c = 0; c < n; c++) begin
            for (int l = 0; l < L; l++) begin
                en[l] = ($urandom_range(0, 3) != 0);
                op[l*13 +: 13] = 13'($urandom());
                r = $urandom_range(0, 9);
                fa[l*5 +: 5] = (r <= NS) ? 5'(r) : 5'($urandom_range(NS+1, 31));
                r = $urandom_range(0, 9);
                fb[l*5 +: 5] = (r <= NS) ? 5'(r) : 5'($urandom_range(NS+1, 31));
                a[l*W +: W] = rnd_w();
                b[l*W +: W] = ($urandom_range(0, 3) == 0) ? a[l*W +: W] : rnd_w();
            end
            ifc.u_en = en; ifc.u_op = op; ifc.u_fwdA = fa; ifc.u_fwdB = fb;
            ifc.u_A = a; ifc.u_B = b;
            ifc.alt_inp = ($urandom_range(0, 2) == 0);
            ifc.alt_data = rnd_w();
            model_edge();
            cyc();
            total++; if (ifc.u_ret_en !== m_ret_en) begin bad++; $display("FAIL rand_ret_en c=%0d got=%b exp=%b", c, ifc.u_ret_en, m_ret_en); end
            total++; if (ifc.u_ret !== m_ret) begin bad++; $display("FAIL rand_ret c=%0d got=%h exp=%h", c, ifc.u_ret, m_ret); end
            total++; if (ifc.fuf !== model_fuf()) begin bad++; $display("FAIL rand_fuf c=%0d got=%h exp=%h", c, ifc.fuf, model_fuf()); end
            total++; if (ifc.xi_valid !== m_xiv || ifc.xi_data !== m_xid) begin bad++; $display("FAIL rand_xi c=%0d got=%b/%h exp=%b/%h", c, ifc.xi_valid, ifc.xi_data, m_xiv, m_xid); end
            total++; if (ifc.alt_ovf !== m_ovf) begin bad++; $display("FAIL rand_ovf c=%0d got=%b exp=%b", c, ifc.alt_ovf, m_ovf); end
        end
        idle();
    endtask

    task automatic test_small_build();
        logic [W2-1:0] v [4];
        logic [W2-1:0] p;
        idle();
        for (int i = 0; i < 4; i++) v[i] = 16'($urandom()) ^ 16'(i * 16'h1357);
        p = ~v[0];
        for (int i = 0; i < 4; i++) begin
            ifc2.u_en = 1'b1; ifc2.u_op = 13'd0; ifc2.u_A = v[i];
            cyc();
        end
        idle();
        cyc();
        for (int d = 0; d < 3; d++) begin
            total++; if (ifc2.fuf[d*W2 +: W2] !== v[2-d]) begin bad++; $display("FAIL small_mid d=%0d got=%h exp=%h", d, ifc2.fuf[d*W2 +: W2], v[2-d]); end
        end
        cyc();
        for (int d = 0; d < 4; d++) begin
            total++; if (ifc2.fuf[d*W2 +: W2] !== v[3-d]) begin bad++; $display("FAIL small_hist d=%0d got=%h exp=%h", d, ifc2.fuf[d*W2 +: W2], v[3-d]); end
        end
        ifc2.u_en = 1'b1; ifc2.u_fwdA = 5'd4; ifc2.u_A = ~v[0] ^ 16'h00FF;
        cyc();
        ifc2.u_fwdA = 5'($urandom_range(5, 31)); ifc2.u_A = p;
        cyc();
        idle();
        cyc();
        total++; if (ifc2.u_ret_en !== 1'b1 || ifc2.u_ret !== 14'h001) begin bad++; $display("FAIL small_code4 got=%b/%h exp=1/001", ifc2.u_ret_en, ifc2.u_ret); end
        total++; if (ifc2.fuf[W2-1:0] !== v[0]) begin bad++; $display("FAIL small_fwd got=%h exp=%h", ifc2.fuf[W2-1:0], v[0]); end
        cyc();
        total++; if (ifc2.u_ret !== 14'h005) begin bad++; $display("FAIL small_flag got=%h exp=005", ifc2.u_ret); end
        total++; if (ifc2.fuf[W2-1:0] !== p || ifc2.fuf[2*W2-1:W2] !== v[0]) begin bad++; $display("FAIL small_port got=%h exp=%h", ifc2.fuf[2*W2-1:0], {v[0], p}); end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_xor();
        test_forward();
        test_bad_op();
        test_alt();
        test_reset_midflight();
        test_random(400);
        test_small_build();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
